// File: rtl/nonlinear_decryption_module3.sv
// Inverts c[i] = m[i] ^ (m[i+1] & k[i]), with m = p ^ k, by walking the ring one bit per clock.
// The walk starts from the lowest clear key bit, where m equals c directly.
module nonlinear_decryption_module3 #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] c_in,
    input  logic [N-1:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] data_out,
    output logic         err
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECOVER,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  c_q, c_d;
    logic [N-1:0]  k_q, k_d;
    logic [N-1:0]  m_q, m_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  data_q, data_d;
    logic          err_q, err_d;

    logic [IW-1:0] firstZero;
    logic [IW-1:0] startIdx;
    logic [IW-1:0] idxUp;
    logic [IW-1:0] idxDown;
    logic [N-1:0]  mNext;

    // Scanning downward lets the lowest clear bit win.
    always_comb begin
        firstZero = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!key[i]) begin
                firstZero = IW'(i);
            end
        end
    end

    always_comb begin
        startIdx = (firstZero == '0) ? LAST : firstZero - IW'(1);
        idxUp    = (idx_q == LAST) ? '0 : idx_q + IW'(1);
        idxDown  = (idx_q == '0) ? LAST : idx_q - IW'(1);
        mNext          = m_q;
        mNext[idx_q]   = c_q[idx_q] ^ (m_q[idxUp] & k_q[idx_q]);
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        k_d     = k_q;
        m_d     = m_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    c_d = c_in;
                    k_d = key;
                    if (&key) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        m_d            = '0;
                        m_d[firstZero] = c_in[firstZero];
                        idx_d          = startIdx;
                        cnt_d          = LAST;
                        state_d        = RECOVER;
                    end
                end
            end
            RECOVER: begin
                m_d   = mNext;
                idx_d = idxDown;
                cnt_d = cnt_q - IW'(1);
                if (cnt_q == IW'(1)) begin
                    data_d  = mNext ^ k_q;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            k_q     <= '0;
            m_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            k_q     <= k_d;
            m_q     <= m_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign data_out  = data_q;
    assign err       = err_q;

endmodule
